// File: rtl/core_vector_sequencer.sv
// Vector sequencer: fetches host vectors, drives them onto a clocked core,
// waits a settle window, then captures and compares the masked response.
module core_vector_sequencer #(
  parameter int IN_W   = 6,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 3,
  parameter int ERR_W  = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [7:0]       num_vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_stim,
  input  logic [OUT_W-1:0] vec_exp,
  input  logic [OUT_W-1:0] vec_mask,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [7:0]       first_fail_idx,
  output logic [OUT_W-1:0] last_resp
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_APPLY  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       settle_q, settle_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [IN_W-1:0]  core_in_q, core_in_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [7:0]       ffi_q, ffi_d;
  logic [OUT_W-1:0] last_resp_q, last_resp_d;
  logic             mismatch;

  assign mismatch = |((core_out ^ exp_q) & mask_q);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    exp_d       = exp_q;
    mask_d      = mask_q;
    core_in_d   = core_in_q;
    err_cnt_d   = err_cnt_q;
    fail_seen_d = fail_seen_q;
    ffi_d       = ffi_q;
    last_resp_d = last_resp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_cnt_d   = '0;
          fail_seen_d = 1'b0;
          ffi_d       = '0;
          last_resp_d = '0;
          idx_d       = '0;
          num_d       = num_vec;
          state_d     = (num_vec != 8'd0) ? S_FETCH : S_FINISH;
        end
      end
      S_FETCH: begin
        if (vec_valid) begin
          exp_d     = vec_exp;
          mask_d    = vec_mask;
          core_in_d = vec_stim;
          settle_d  = SETTLE_M1;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          // Last settle cycle: this edge samples the core response.
          last_resp_d = core_out;
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              ffi_d       = idx_q;
            end
          end
          if (idx_q == num_q - 8'd1) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      core_in_q   <= '0;
      err_cnt_q   <= '0;
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
      last_resp_q <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      core_in_q   <= core_in_d;
      err_cnt_q   <= err_cnt_d;
      fail_seen_q <= fail_seen_d;
      ffi_q       <= ffi_d;
      last_resp_q <= last_resp_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH);
  assign vec_ready      = (state_q == S_FETCH);
  assign core_in        = core_in_q;
  assign err_cnt        = err_cnt_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = ffi_q;
  assign last_resp      = last_resp_q;

endmodule
